nfc_ask_demod: RTL and testbench

// - Receive-side counterpart of the NFC reader transmit path. Takes the sampled, high-pass-filtered

---
 rtl/nfc_demod_pkg.sv | 27 ++
 rtl/nfc_env_detect.sv | 59 +++++
 rtl/nfc_ask_demod.sv | 188 ++++++++++++++++++
 tb/tb_nfc_ask_demod.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_demod_pkg.sv
// Shared types and helpers for the NFC ASK receive demodulator.
package nfc_demod_pkg;

  // Slicer states: committed level plus a pending-change state for each direction.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_FALL,
    S_LOW,
    S_RISE
  } slicer_state_t;

  // Magnitude of a w-bit signed code carried sign-extended in 32 bits. The most negative
  // code has no positive twin, so it folds onto the largest positive code. Valid for w <= 32.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] min_code;
    min_code = 32'sh8000_0000 >>> (32 - w);
    if (x == min_code) begin
      abs_sat = ~min_code;
    end else if (x < 0) begin
      abs_sat = -x;
    end else begin
      abs_sat = x;
    end
  endfunction

endpackage

// File: rtl/nfc_env_detect.sv
// Window envelope detector: |v_in| peak over WIN_LEN samples, published once per window.
module nfc_env_detect
  import nfc_demod_pkg::*;
#(
  parameter int IN_WIDTH = 18,
  parameter int WIN_LEN  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IN_WIDTH-1:0] i_v_in,
  output logic        [IN_WIDTH-2:0] o_env,
  output logic                       o_env_valid
);

  localparam int ENV_W = IN_WIDTH - 1;
  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);

  logic [31:0]      w_abs_full;
  logic [ENV_W-1:0] w_abs;
  logic [ENV_W-1:0] w_max;
  logic             w_unused_abs;
  logic [CNT_W-1:0] r_cnt;
  logic [ENV_W-1:0] r_run;
  logic [ENV_W-1:0] r_env;
  logic             r_env_valid;

  // The saturated magnitude always fits in IN_WIDTH-1 bits; the upper bits are structurally zero.
  assign w_abs_full   = abs_sat(32'(i_v_in), IN_WIDTH);
  assign w_abs        = w_abs_full[ENV_W-1:0];
  assign w_unused_abs = ^w_abs_full[31:ENV_W];

  // Peak including the current sample, so the last sample of a window lands in that window.
  assign w_max = (w_abs > r_run) ? w_abs : r_run;

  // Window counter and running max; on the last sample publish the peak and restart from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_cnt       <= '0;
      r_run       <= '0;
      r_env       <= '0;
      r_env_valid <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt       <= '0;
      r_run       <= '0;
      r_env       <= w_max;
      r_env_valid <= 1'b1;
    end else begin
      r_cnt       <= r_cnt + 1'b1;
      r_run       <= w_max;
      r_env_valid <= 1'b0;
    end
  end

  assign o_env       = r_env;
  assign o_env_valid = r_env_valid;

endmodule

// File: rtl/nfc_ask_demod.sv
// NFC ASK demodulator: envelope per window, hysteresis/debounce slicer, edge and pulse-length report.
module nfc_ask_demod
  import nfc_demod_pkg::*;
#(
  parameter int IN_WIDTH  = 18,
  parameter int WIN_LEN   = 8,
  parameter int TH_HI     = 4500,
  parameter int TH_LO     = 4300,
  parameter int DEBOUNCE  = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IN_WIDTH-1:0] i_v_in,
  output logic        [IN_WIDTH-2:0] o_env,
  output logic                       o_env_valid,
  output logic                       o_mod_level,
  output logic                       o_edge_valid,
  output logic                       o_edge_dir,
  output logic       [CNT_WIDTH-1:0] o_pulse_len,
  output logic                       o_len_sat
);

  localparam int ENV_W  = IN_WIDTH - 1;
  localparam int PEND_W = $clog2(DEBOUNCE + 1);
  localparam logic [ENV_W-1:0]     TH_HI_C    = ENV_W'(TH_HI);
  localparam logic [ENV_W-1:0]     TH_LO_C    = ENV_W'(TH_LO);
  localparam logic [CNT_WIDTH-1:0] LEN_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] LEN_RELOAD = CNT_WIDTH'(DEBOUNCE);
  localparam logic [PEND_W-1:0]    PEND_DONE  = PEND_W'(DEBOUNCE);

  logic [ENV_W-1:0]     w_env;
  logic                 w_env_valid;
  logic                 w_hi;
  logic                 w_lo;
  logic                 w_commit;
  logic [PEND_W-1:0]    w_pend_inc;
  logic [PEND_W-1:0]    w_pend_nxt;
  logic [CNT_WIDTH-1:0] w_len_inc;
  slicer_state_t        w_state_nxt;
  slicer_state_t        r_state;
  logic [PEND_W-1:0]    r_pend;
  logic [CNT_WIDTH-1:0] r_len;
  logic                 r_edge_valid;
  logic                 r_edge_dir;
  logic [CNT_WIDTH-1:0] r_pulse_len;
  logic                 r_len_sat;

  nfc_env_detect #(
    .IN_WIDTH (IN_WIDTH),
    .WIN_LEN  (WIN_LEN)
  ) u_env_detect (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_v_in      (i_v_in),
    .o_env       (w_env),
    .o_env_valid (w_env_valid)
  );

  // Values between TH_LO and TH_HI are neither hi nor lo, which gives the hysteresis band.
  assign w_hi       = (w_env >= TH_HI_C);
  assign w_lo       = (w_env < TH_LO_C);
  assign w_pend_inc = r_pend + 1'b1;
  assign w_len_inc  = (r_len == LEN_MAX) ? r_len : r_len + 1'b1;

  // Slicer state and pending-window count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Next state: only a completed window moves the slicer; a commit ends a debounced run.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_commit    = 1'b0;
    if (w_env_valid) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = w_hi ? S_HIGH : S_LOW;
          w_pend_nxt  = '0;
        end
        S_HIGH: begin
          if (w_lo) begin
            if (DEBOUNCE == 1) begin
              w_state_nxt = S_LOW;
              w_commit    = 1'b1;
            end else begin
              w_state_nxt = S_FALL;
              w_pend_nxt  = PEND_W'(1);
            end
          end
        end
        S_FALL: begin
          if (!w_lo) begin
            w_state_nxt = S_HIGH;
            w_pend_nxt  = '0;
          end else if (w_pend_inc == PEND_DONE) begin
            w_state_nxt = S_LOW;
            w_pend_nxt  = '0;
            w_commit    = 1'b1;
          end else begin
            w_pend_nxt  = w_pend_inc;
          end
        end
        S_LOW: begin
          if (w_hi) begin
            if (DEBOUNCE == 1) begin
              w_state_nxt = S_HIGH;
              w_commit    = 1'b1;
            end else begin
              w_state_nxt = S_RISE;
              w_pend_nxt  = PEND_W'(1);
            end
          end
        end
        S_RISE: begin
          if (!w_hi) begin
            w_state_nxt = S_LOW;
            w_pend_nxt  = '0;
          end else if (w_pend_inc == PEND_DONE) begin
            w_state_nxt = S_HIGH;
            w_pend_nxt  = '0;
            w_commit    = 1'b1;
          end else begin
            w_pend_nxt  = w_pend_inc;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = '0;
        end
      endcase
    end
  end

  // Committed level: a pending change has not happened yet, so FALL still reads high.
  always_comb begin
    o_mod_level = (r_state == S_HIGH) || (r_state == S_FALL);
  end

  // Windows spent in the current level. The IDLE window already belongs to the first level,
  // and after a commit the debounced windows belong to the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
    end else if (w_env_valid) begin
      if (r_state == S_IDLE) begin
        r_len <= CNT_WIDTH'(1);
      end else if (w_commit) begin
        r_len <= LEN_RELOAD;
      end else begin
        r_len <= w_len_inc;
      end
    end
  end

  // Edge report: strobe for one cycle, length and saturation flag hold until the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_valid <= 1'b0;
      r_edge_dir   <= 1'b0;
      r_pulse_len  <= '0;
      r_len_sat    <= 1'b0;
    end else begin
      r_edge_valid <= w_commit;
      if (w_commit) begin
        r_edge_dir  <= (w_state_nxt == S_HIGH);
        r_pulse_len <= w_len_inc;
        r_len_sat   <= (w_len_inc == LEN_MAX);
      end
    end
  end

  assign o_env        = w_env;
  assign o_env_valid  = w_env_valid;
  assign o_edge_valid = r_edge_valid;
  assign o_edge_dir   = r_edge_dir;
  assign o_pulse_len  = r_pulse_len;
  assign o_len_sat    = r_len_sat;

endmodule

// File: tb/tb_nfc_ask_demod.sv
// Scoreboard bench for nfc_ask_demod: a window-level reference model queues expectations,
// a negedge monitor compares them as the DUT strobes env_valid / edge_valid.
module tb_nfc_ask_demod;

  localparam int IN_WIDTH  = 18;
  localparam int WIN_LEN   = 8;
  localparam int TH_HI     = 4500;
  localparam int TH_LO     = 4300;
  localparam int DEBOUNCE  = 2;
  localparam int CNT_WIDTH = 8;
  localparam int AMP_MAX   = 131071;
  localparam int CODE_MIN  = -131072;
  localparam int LEN_CAP   = 255;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic signed [IN_WIDTH-1:0] v_in = '0;
  logic        [IN_WIDTH-2:0] env;
  logic                       env_valid;
  logic                       mod_level;
  logic                       edge_valid;
  logic                       edge_dir;
  logic       [CNT_WIDTH-1:0] pulse_len;
  logic                       len_sat;

  nfc_ask_demod #(
    .IN_WIDTH  (IN_WIDTH),
    .WIN_LEN   (WIN_LEN),
    .TH_HI     (TH_HI),
    .TH_LO     (TH_LO),
    .DEBOUNCE  (DEBOUNCE),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_v_in       (v_in),
    .o_env        (env),
    .o_env_valid  (env_valid),
    .o_mod_level  (mod_level),
    .o_edge_valid (edge_valid),
    .o_edge_dir   (edge_dir),
    .o_pulse_len  (pulse_len),
    .o_len_sat    (len_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int env;
    bit level;
    bit edge_ev;
    bit dir;
    int len;
    bit sat;
  } exp_win_t;

  exp_win_t exp_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  // Reference model: committed level, run of consecutive opposite-qualifying windows,
  // and windows attributed to the current level.
  bit m_started = 0;
  bit m_level   = 0;
  int m_run     = 0;
  int m_nwin    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_level   = 0;
    m_run     = 0;
    m_nwin    = 0;
    exp_q.delete();
  endtask

  task automatic model_window(input int s[WIN_LEN]);
    int       pk;
    int       a;
    bit       qual;
    exp_win_t w;
    pk = 0;
    for (int i = 0; i < WIN_LEN; i++) begin
      a  = (s[i] == CODE_MIN) ? AMP_MAX : ((s[i] < 0) ? -s[i] : s[i]);
      pk = (a > pk) ? a : pk;
    end
    w.env = pk; w.edge_ev = 0; w.dir = 0; w.len = 0; w.sat = 0;
    if (!m_started) begin
      m_started = 1;
      m_level   = (pk >= TH_HI);
      m_nwin    = 1;
      m_run     = 0;
    end else begin
      m_nwin++;
      qual  = m_level ? (pk < TH_LO) : (pk >= TH_HI);
      m_run = qual ? m_run + 1 : 0;
      if (m_run == DEBOUNCE) begin
        w.edge_ev = 1;
        w.dir     = !m_level;
        w.len     = (m_nwin > LEN_CAP) ? LEN_CAP : m_nwin;
        w.sat     = (m_nwin >= LEN_CAP);
        m_level   = !m_level;
        m_nwin    = DEBOUNCE;
        m_run     = 0;
      end
    end
    w.level = m_level;
    exp_q.push_back(w);
  endtask

  // kind 0: square carrier +amp/-amp; kind 1: random samples with one peak of +/-amp;
  // kind 2: random full-scale samples with one most-negative code.
  task automatic drive_window(input int amp, input int kind);
    int s[WIN_LEN];
    int pos;
    pos = int'($urandom_range(WIN_LEN - 1));
    for (int i = 0; i < WIN_LEN; i++) begin
      if (kind == 0) s[i] = (i < WIN_LEN / 2) ? amp : -amp;
      else           s[i] = int'($urandom_range(2 * amp)) - amp;
    end
    if (kind == 1) s[pos] = ($urandom_range(1) == 1) ? amp : -amp;
    if (kind == 2) s[pos] = CODE_MIN;
    model_window(s);
    for (int i = 0; i < WIN_LEN; i++) begin
      v_in = IN_WIDTH'(s[i]);
      @(negedge clk);
    end
  endtask

  task automatic drive_raw(input int n, input int amp);
    for (int i = 0; i < n; i++) begin
      v_in = IN_WIDTH'(amp);
      @(negedge clk);
    end
  endtask

  function automatic int pick_amp(input int cls);
    if (cls == 0)      return int'($urandom_range(TH_LO - 1));
    else if (cls == 1) return int'($urandom_range(TH_HI - 1, TH_LO));
    else               return int'($urandom_range(20000, TH_HI));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_env"},        env,        0);
    check({tag, "_env_valid"},  env_valid,  0);
    check({tag, "_mod_level"},  mod_level,  0);
    check({tag, "_edge_valid"}, edge_valid, 0);
    check({tag, "_edge_dir"},   edge_dir,   0);
    check({tag, "_pulse_len"},  pulse_len,  0);
    check({tag, "_len_sat"},    len_sat,    0);
  endtask

  // Monitor: env at each env_valid, then level and edge report in the following cycle.
  bit       chk_next  = 0;
  bit       env_seen  = 0;
  int       cyc       = 0;
  exp_win_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk_next = 0;
      env_seen = 0;
      cyc      = 0;
    end else begin
      cyc++;
      if (chk_next) begin
        check("mod_level", mod_level, cur.level);
        check("edge_valid", edge_valid, cur.edge_ev);
        if (cur.edge_ev) begin
          check("edge_dir",  edge_dir,  cur.dir);
          check("pulse_len", pulse_len, cur.len);
          check("len_sat",   len_sat,   cur.sat);
        end
        chk_next = 0;
      end else if (edge_valid) begin
        check("edge_valid_stray", edge_valid, 0);
      end
      if (env_valid) begin
        if (!env_seen) begin
          check("first_env_cycle", cyc, WIN_LEN);
          env_seen = 1;
        end
        if (exp_q.size() == 0) begin
          check("env_valid_stray", env_valid, 0);
        end else begin
          cur = exp_q.pop_front();
          check("env", env, cur.env);
          chk_next = 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #1 rst_n = 1'b1;

    // IDLE entry high, then a debounced fall (12 windows in the high level) and a rise.
    for (int i = 0; i < 10; i++) drive_window(5000, 0);
    for (int i = 0; i < 2; i++)  drive_window(4000, 0);
    for (int i = 0; i < 3; i++)  drive_window(5000, 0);

    // Single low window inside a high run is rejected.
    for (int i = 0; i < 4; i++) drive_window(pick_amp(2), 1);
    drive_window(4000, 1);
    for (int i = 0; i < 4; i++) drive_window(pick_amp(2), 1);

    // Hysteresis band from HIGH, then from LOW.
    for (int i = 0; i < 20; i++) drive_window(pick_amp(1), 1);
    for (int i = 0; i < 2; i++)  drive_window(pick_amp(0), 1);
    for (int i = 0; i < 20; i++) drive_window(pick_amp(1), 1);
    for (int i = 0; i < 2; i++)  drive_window(pick_amp(2), 1);

    // Most negative code and pulse-length saturation.
    drive_window(AMP_MAX, 2);
    for (int i = 0; i < 300; i++) drive_window(int'($urandom_range(60000, TH_HI)), 1);
    for (int i = 0; i < 2; i++)   drive_window(pick_amp(0), 1);

    // Random runs of lo / band / hi windows.
    for (int k = 0; k < 60; k++) begin
      int cls;
      int run;
      cls = int'($urandom_range(2));
      run = int'($urandom_range(4, 1));
      for (int j = 0; j < run; j++) drive_window(pick_amp(cls), 1);
    end

    // Async reset while a fall is pending, part-way through the next window.
    for (int i = 0; i < 3; i++) drive_window(pick_amp(2), 1);
    drive_window(pick_amp(0), 1);
    drive_raw(3, 4000);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Re-entry via IDLE low without an edge, then a rise counting the IDLE window.
    drive_window(pick_amp(0), 1);
    for (int i = 0; i < 2; i++) drive_window(pick_amp(2), 1);
    for (int i = 0; i < 5; i++) drive_window(pick_amp(int'($urandom_range(2))), 1);

    drive_raw(3, 0);
    check("queue_drained", exp_q.size(), 0);
    check("no_pending_check", chk_next, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
